wordle_engine: RTL and testbench

WORDLE_ENGINE -- requirements
Module: wordle_engine

---
 rtl/wordle_engine.sv | 265 ++++++++++++++++++++++++++
 tb/tb_wordle_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wordle_engine.sv
// Wordle scoring engine: collects a guess letter by letter, scores it against a
// latched target (greens first, then yellows with per-letter accounting), tracks win/lose.
module wordle_engine #(
  parameter int WORD_LEN    = 5,
  parameter int MAX_GUESSES = 6
) (
  input  logic                    Clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [8*WORD_LEN-1:0]   target_word,
  input  logic                    letter_valid,
  input  logic [7:0]              letter,
  input  logic                    backspace,
  input  logic                    submit,
  input  logic                    ack,
  output logic [8*WORD_LEN-1:0]   guess_word,
  output logic [3:0]              letter_count,
  output logic [3:0]              guess_num,
  output logic [2*WORD_LEN-1:0]   score,
  output logic                    score_valid,
  output logic                    entry_err,
  output logic                    busy,
  output logic                    win,
  output logic                    lose,
  output logic [2:0]              state_dbg
);

  // Handshake: every input is a single-cycle strobe sampled on the rising edge;
  // entry inputs only act in ENTRY, and while busy is high they are dropped silently.

  localparam logic [3:0] LEN  = 4'(WORD_LEN);
  localparam logic [3:0] LAST = 4'(WORD_LEN - 1);
  localparam logic [3:0] GMAX = 4'(MAX_GUESSES);

  localparam logic [1:0] GRAY   = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    SCORE_G = 3'd2,
    SCORE_Y = 3'd3,
    REPORT  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [7:0]          target_q [WORD_LEN];
  logic [7:0]          guess_q  [WORD_LEN];
  logic [1:0]          score_q  [WORD_LEN];
  logic [WORD_LEN-1:0] used_q;
  logic [3:0]          count_q, gnum_q, idx_i, idx_j;
  logic                win_q, lose_q, err_q;

  logic [7:0] g_i, t_i, t_j;
  logic [1:0] s_i;
  logic       u_j, all_green, is_upper;
  logic       do_start, do_write, do_back, do_err, do_accept, do_next;
  logic       set_win, set_lose, do_ack;

  // Per-index operand selection for the scoring scan
  always_comb begin
    g_i       = 8'h00;
    t_i       = 8'h00;
    t_j       = 8'h00;
    s_i       = GRAY;
    u_j       = 1'b0;
    all_green = 1'b1;
    for (int p = 0; p < WORD_LEN; p++) begin
      if (idx_i == 4'(p)) begin
        g_i = guess_q[p];
        t_i = target_q[p];
        s_i = score_q[p];
      end
      if (idx_j == 4'(p)) begin
        t_j = target_q[p];
        u_j = used_q[p];
      end
      if (score_q[p] != GREEN) all_green = 1'b0;
    end
  end

  assign is_upper = (letter >= 8'h41) && (letter <= 8'h5A);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_write  = 1'b0;
    do_back   = 1'b0;
    do_err    = 1'b0;
    do_accept = 1'b0;
    do_next   = 1'b0;
    set_win   = 1'b0;
    set_lose  = 1'b0;
    do_ack    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ENTRY;
          do_start = 1'b1;
        end
      end
      ENTRY: begin
        if (submit) begin
          if (count_q == LEN) begin
            state_d   = SCORE_G;
            do_accept = 1'b1;
          end else begin
            do_err = 1'b1;
          end
        end else if (backspace) begin
          do_back = (count_q != 4'd0);
        end else if (letter_valid) begin
          if (is_upper && (count_q < LEN)) do_write = 1'b1;
          else                             do_err   = 1'b1;
        end
      end
      SCORE_G: begin
        if (idx_i == LAST) state_d = SCORE_Y;
      end
      SCORE_Y: begin
        if ((idx_i == LAST) && (idx_j == LAST)) state_d = REPORT;
      end
      REPORT: begin
        if (all_green) begin
          state_d = DONE;
          set_win = 1'b1;
        end else if (gnum_q == GMAX) begin
          state_d  = DONE;
          set_lose = 1'b1;
        end else begin
          state_d = ENTRY;
          do_next = 1'b1;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
          do_ack  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < WORD_LEN; p++) begin
        target_q[p] <= 8'h00;
        guess_q[p]  <= 8'h00;
        score_q[p]  <= GRAY;
      end
      used_q  <= '0;
      count_q <= 4'd0;
      gnum_q  <= 4'd0;
      idx_i   <= 4'd0;
      idx_j   <= 4'd0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= do_err;

      if (do_start) begin
        for (int p = 0; p < WORD_LEN; p++) begin
          target_q[p] <= target_word[8*(WORD_LEN-1-p) +: 8];
          guess_q[p]  <= 8'h00;
          score_q[p]  <= GRAY;
        end
        count_q <= 4'd0;
        gnum_q  <= 4'd1;
        win_q   <= 1'b0;
        lose_q  <= 1'b0;
      end

      if (do_write) begin
        for (int p = 0; p < WORD_LEN; p++)
          if (count_q == 4'(p)) guess_q[p] <= letter;
        count_q <= count_q + 4'd1;
      end

      if (do_back) begin
        for (int p = 0; p < WORD_LEN; p++)
          if (count_q == 4'(p + 1)) guess_q[p] <= 8'h00;
        count_q <= count_q - 4'd1;
      end

      // Every position starts gray with no target letter consumed
      if (do_accept) begin
        for (int p = 0; p < WORD_LEN; p++) score_q[p] <= GRAY;
        used_q <= '0;
        idx_i  <= 4'd0;
        idx_j  <= 4'd0;
      end

      if (state_q == SCORE_G) begin
        if (g_i == t_i) begin
          for (int p = 0; p < WORD_LEN; p++)
            if (idx_i == 4'(p)) begin
              score_q[p] <= GREEN;
              used_q[p]  <= 1'b1;
            end
        end
        idx_i <= (idx_i == LAST) ? 4'd0 : idx_i + 4'd1;
      end

      // Consuming target letters via used_q caps yellows of a repeated letter
      if (state_q == SCORE_Y) begin
        if ((s_i == GRAY) && !u_j && (g_i == t_j)) begin
          for (int p = 0; p < WORD_LEN; p++) begin
            if (idx_i == 4'(p)) score_q[p] <= YELLOW;
            if (idx_j == 4'(p)) used_q[p]  <= 1'b1;
          end
        end
        if (idx_j == LAST) begin
          idx_j <= 4'd0;
          idx_i <= (idx_i == LAST) ? 4'd0 : idx_i + 4'd1;
        end else begin
          idx_j <= idx_j + 4'd1;
        end
      end

      if (do_next) begin
        for (int p = 0; p < WORD_LEN; p++) guess_q[p] <= 8'h00;
        count_q <= 4'd0;
        gnum_q  <= gnum_q + 4'd1;
      end

      if (set_win)  win_q  <= 1'b1;
      if (set_lose) lose_q <= 1'b1;

      if (do_ack) begin
        win_q  <= 1'b0;
        lose_q <= 1'b0;
        gnum_q <= 4'd0;
      end
    end
  end

  always_comb begin
    guess_word = '0;
    score      = '0;
    for (int p = 0; p < WORD_LEN; p++) begin
      guess_word[8*(WORD_LEN-1-p) +: 8] = guess_q[p];
      score[2*(WORD_LEN-1-p) +: 2]      = score_q[p];
    end
  end

  assign letter_count = count_q;
  assign guess_num    = gnum_q;
  assign score_valid  = (state_q == REPORT);
  assign busy         = (state_q == SCORE_G) || (state_q == SCORE_Y) || (state_q == REPORT);
  assign entry_err    = err_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_wordle_engine.sv
// Directed bench for wordle_engine (L=5, G=6): entry rules, scoring vectors,
// report latency, win/lose paths and asynchronous reset mid-score.
module tb_wordle_engine;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        start, letter_valid, backspace, submit, ack;
  logic [39:0] target_word;
  logic [7:0]  letter;
  logic [39:0] guess_word;
  logic [3:0]  letter_count, guess_num;
  logic [9:0]  score;
  logic        score_valid, entry_err, busy, win, lose;
  logic [2:0]  state_dbg;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   edges;
  logic err_seen;

  wordle_engine #(.WORD_LEN(5), .MAX_GUESSES(6)) dut (
    .Clk(Clk), .reset_n(reset_n), .start(start), .target_word(target_word),
    .letter_valid(letter_valid), .letter(letter), .backspace(backspace),
    .submit(submit), .ack(ack), .guess_word(guess_word),
    .letter_count(letter_count), .guess_num(guess_num), .score(score),
    .score_valid(score_valid), .entry_err(entry_err), .busy(busy),
    .win(win), .lose(lose), .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_game(input logic [39:0] tw);
    target_word = tw;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic enter_word(input string w);
    for (int k = 0; k < w.len(); k++) begin
      letter_valid = 1'b1;
      letter = w[k];
      step();
    end
    letter_valid = 1'b0;
  endtask

  // The accepting edge counts as edge 1; returns when score_valid is seen
  task automatic submit_wait(output int n);
    err_seen = 1'b0;
    submit = 1'b1;
    step();
    n = 1;
    submit = 1'b0;
    err_seen = err_seen | entry_err;
    while (score_valid !== 1'b1 && n < 100) begin
      step();
      n++;
      err_seen = err_seen | entry_err;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; letter_valid = 1'b0; backspace = 1'b0;
    submit = 1'b0; ack = 1'b0; letter = 8'h00; target_word = '0;
    step(); step();
    check("rst_guess_word", guess_word, 0);
    check("rst_outputs", {letter_count, guess_num, score}, 0);
    check("rst_flags", {score_valid, entry_err, busy, win, lose}, 0);
    reset_n = 1'b1;
    step();

    // Game 1: target ROBOT
    begin_game("ROBOT");
    check("start_guess_num", guess_num, 1);
    check("start_count", letter_count, 0);
    enter_word("BOOST");
    check("buf_boost", guess_word, "BOOST");
    check("count_full", letter_count, 5);
    submit_wait(edges);
    check("report_edges", edges, 31);
    check("score_boost", score, 10'h192);
    check("busy_report", busy, 1);
    step();
    check("next_guess_num", guess_num, 2);
    check("next_cleared", {letter_count, guess_word}, 0);
    check("score_held", score, 10'h192);
    check("no_win_yet", {win, lose, busy}, 0);

    // Entry rules on guess 2
    backspace = 1'b1; step(); backspace = 1'b0;
    check("bs_empty_err", entry_err, 0);
    check("bs_empty_cnt", letter_count, 0);
    letter_valid = 1'b1; letter = 8'h61; step(); letter_valid = 1'b0;
    check("lower_err", entry_err, 1);
    check("lower_cnt", letter_count, 0);
    enter_word("ABC");
    check("abc_err_clear", entry_err, 0);
    submit = 1'b1; step(); submit = 1'b0;
    check("short_submit_err", entry_err, 1);
    check("short_submit_cnt", letter_count, 3);
    check("short_submit_busy", busy, 0);
    letter_valid = 1'b1; letter = "D"; backspace = 1'b1; step();
    letter_valid = 1'b0; backspace = 1'b0;
    check("bs_priority_cnt", letter_count, 2);
    check("bs_priority_buf", guess_word, 40'h4142000000);
    check("bs_priority_err", entry_err, 0);
    enter_word("CDE");
    check("buf_abcde", guess_word, "ABCDE");
    letter_valid = 1'b1; letter = "F"; step(); letter_valid = 1'b0;
    check("full_err", entry_err, 1);
    check("full_buf", guess_word, "ABCDE");

    // Entry inputs held throughout scoring must be ignored
    letter_valid = 1'b1; letter = "Q"; backspace = 1'b1;
    submit_wait(edges);
    letter_valid = 1'b0; backspace = 1'b0;
    check("busy_ignore_err", err_seen, 0);
    check("busy_ignore_buf", guess_word, "ABCDE");
    check("score_abcde", score, 10'h040);
    step();
    check("guess3_num", guess_num, 3);

    // start mid-game ignored; winning with ROBOT proves target not resampled
    target_word = "CRIMP"; start = 1'b1; step(); start = 1'b0;
    check("start_ignored", {guess_num, letter_count}, {4'd3, 4'd0});
    enter_word("ROBOT");
    submit_wait(edges);
    check("score_robot", score, 10'h2AA);
    step();
    check("win_g3", {win, lose, busy}, 3'b100);
    check("win_g3_num", guess_num, 3);
    ack = 1'b1; step(); ack = 1'b0;
    check("ack_g1", {win, lose, guess_num}, 0);

    // Game 2: repeated letters, then reset while scoring
    begin_game("ABBOT");
    enter_word("BBBBB");
    submit_wait(edges);
    check("score_bbbbb", score, 10'h0A0);
    step();
    enter_word("TOBAB");
    submit = 1'b1; step(); submit = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("busy_mid_score", busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_buf", guess_word, 0);
    check("midrst_vals", {letter_count, guess_num, score}, 0);
    check("midrst_flags", {score_valid, entry_err, busy, win, lose}, 0);
    step();
    reset_n = 1'b1;
    step();

    // Game 3: immediate win
    begin_game("CRIMP");
    check("clean_start", {guess_num, letter_count, guess_word}, {4'd1, 4'd0, 40'h0});
    check("clean_score", score, 0);
    enter_word("CRIMP");
    submit_wait(edges);
    check("crimp_edges", edges, 31);
    check("score_crimp", score, 10'h2AA);
    step();
    check("crimp_win", {win, lose}, 2'b10);
    check("crimp_num", guess_num, 1);
    begin_game("ZZZZZ");
    check("done_start_ignored", {win, guess_num}, {1'b1, 4'd1});
    check("done_buf_held", guess_word, "CRIMP");
    ack = 1'b1; step(); ack = 1'b0;
    check("crimp_ack", {win, lose, guess_num}, 0);

    // Game 4: six misses
    begin_game("CRIMP");
    for (int g = 1; g <= 6; g++) begin
      enter_word("ZZZZZ");
      submit_wait(edges);
      check("miss_score", score, 0);
      step();
      if (g < 6) check("miss_continue", {guess_num, lose}, {4'(g + 1), 1'b0});
    end
    check("lose_flags", {win, lose, busy}, 3'b010);
    check("lose_num", guess_num, 6);
    ack = 1'b1; step(); ack = 1'b0;
    check("lose_ack", {win, lose, guess_num}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
